// File: rtl/regbank_pkg.sv
// regbank_pkg: shared constants and types for the register-bank write-port
// arbiter.
//   SIZE     : data width of a register write
//   ADDR_W   : register index width
//   CNT_W    : width of the committed-write counter
//   wr_req_t : one writeback request (destination register + data)
//   grant_t  : which requester was granted last (round-robin state)
package regbank_pkg;

    localparam int unsigned SIZE   = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned CNT_W  = 16;

    typedef struct packed {
        logic [ADDR_W-1:0] reg_idx;
        logic [SIZE-1:0]   data;
    } wr_req_t;

    typedef enum logic {
        GNT_A = 1'b0,
        GNT_B = 1'b1
    } grant_t;

endpackage

// File: rtl/regbank_wport_arb_if.sv
// regbank_wport_arb_if: bundle of the requester, decode and bank-side
// signals of the write-port arbiter.
//   A_VALID/A_REG/A_DATA, B_VALID/B_REG/B_DATA : writeback requests
//   A_READY/B_READY                            : request accepted this cycle
//   RS1/RS2                                    : decode source registers
//   HAZ1/HAZ2, BYPn_VALID/BYPn_DATA            : hazard and forwarding flags
//   ENA_WRITE/WRITE_REG/WRITE_DATA             : registered bank write port
//   WR_COUNT                                   : committed non-x0 writes
// Modport slave is the arbiter side, master is the requester/decode side.
interface regbank_wport_arb_if #(
    parameter int unsigned SIZE   = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 16
);

    logic              A_VALID;
    logic [ADDR_W-1:0] A_REG;
    logic [SIZE-1:0]   A_DATA;
    logic              A_READY;

    logic              B_VALID;
    logic [ADDR_W-1:0] B_REG;
    logic [SIZE-1:0]   B_DATA;
    logic              B_READY;

    logic [ADDR_W-1:0] RS1;
    logic [ADDR_W-1:0] RS2;
    logic              HAZ1;
    logic              HAZ2;
    logic              BYP1_VALID;
    logic              BYP2_VALID;
    logic [SIZE-1:0]   BYP1_DATA;
    logic [SIZE-1:0]   BYP2_DATA;

    logic              ENA_WRITE;
    logic [ADDR_W-1:0] WRITE_REG;
    logic [SIZE-1:0]   WRITE_DATA;
    logic [CNT_W-1:0]  WR_COUNT;

    modport slave (
        input  A_VALID, A_REG, A_DATA,
        input  B_VALID, B_REG, B_DATA,
        input  RS1, RS2,
        output A_READY, B_READY,
        output HAZ1, HAZ2,
        output BYP1_VALID, BYP2_VALID, BYP1_DATA, BYP2_DATA,
        output ENA_WRITE, WRITE_REG, WRITE_DATA, WR_COUNT
    );

    modport master (
        output A_VALID, A_REG, A_DATA,
        output B_VALID, B_REG, B_DATA,
        output RS1, RS2,
        input  A_READY, B_READY,
        input  HAZ1, HAZ2,
        input  BYP1_VALID, BYP2_VALID, BYP1_DATA, BYP2_DATA,
        input  ENA_WRITE, WRITE_REG, WRITE_DATA, WR_COUNT
    );

endinterface

// File: rtl/regbank_wport_arb_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
//   clk, rst     : clock and synchronous active-high reset
//   req_a, req_b : requests
//   gnt_a, gnt_b : one-hot grant (combinational, forced low during reset)
// The LAST state moves only when a grant is issued; after reset it holds
// GNT_B so that A wins the first tie.
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);

    import regbank_pkg::*;

    grant_t last_q;
    grant_t last_d;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= GNT_B;
        end else begin
            last_q <= last_d;
        end
    end

    // Next state: remember the winner, hold when nobody is granted
    always_comb begin
        last_d = last_q;
        if (gnt_a) begin
            last_d = GNT_A;
        end else if (gnt_b) begin
            last_d = GNT_B;
        end
    end

    // Outputs: a lone requester wins; on a tie the one not granted last wins
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (!rst) begin
            if (req_a && (!req_b || last_q == GNT_B)) begin
                gnt_a = 1'b1;
            end else if (req_b) begin
                gnt_b = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regbank_wport_arb.sv
// regbank_wport_arb: write-port arbiter and RAW hazard flagging for the
// 32x32 register bank.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : regbank_wport_arb_if.slave (requests, decode sources,
//              hazard/bypass flags, registered bank write port, counter)
// Optional feature macro: REGBANK_BYPASS_EN. When defined, a write held in
// the output stage is forwarded on BYPn_* and no longer raises HAZn; when
// undefined, BYPn_* are tied to zero and the in-flight write raises HAZn.
module regbank_wport_arb #(
    parameter int unsigned SIZE   = regbank_pkg::SIZE,
    parameter int unsigned ADDR_W = regbank_pkg::ADDR_W,
    parameter int unsigned CNT_W  = regbank_pkg::CNT_W
) (
    input logic               CLK,
    input logic               RST,
    regbank_wport_arb_if.slave bus
);

    import regbank_pkg::*;

    logic    gnt_a;
    logic    gnt_b;
    wr_req_t req_a;
    wr_req_t req_b;
    wr_req_t win;
    logic    commit;

    logic              ena_write_q,  ena_write_d;
    logic [ADDR_W-1:0] write_reg_q,  write_reg_d;
    logic [SIZE-1:0]   write_data_q, write_data_d;
    logic [CNT_W-1:0]  wr_count_q,   wr_count_d;

    logic hit_a1, hit_b1, hit_f1;
    logic hit_a2, hit_b2, hit_f2;

    rr_arb2 u_arb (
        .clk   (CLK),
        .rst   (RST),
        .req_a (bus.A_VALID),
        .req_b (bus.B_VALID),
        .gnt_a (gnt_a),
        .gnt_b (gnt_b)
    );

    assign bus.A_READY = gnt_a;
    assign bus.B_READY = gnt_b;

    // Winner selection and output-stage next state. A grant to x0 still
    // consumes the turn but never reaches the bank or the counter.
    always_comb begin
        req_a   = '{reg_idx: bus.A_REG, data: bus.A_DATA};
        req_b   = '{reg_idx: bus.B_REG, data: bus.B_DATA};
        win     = gnt_a ? req_a : req_b;
        commit  = (gnt_a || gnt_b) && (win.reg_idx != '0);

        ena_write_d  = commit;
        write_reg_d  = commit ? win.reg_idx : write_reg_q;
        write_data_d = commit ? win.data    : write_data_q;
        wr_count_d   = (commit && wr_count_q != '1) ? wr_count_q + CNT_W'(1)
                                                    : wr_count_q;
    end

    // Reset also discards any write sitting in the output stage.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ena_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            wr_count_q   <= '0;
        end else begin
            ena_write_q  <= ena_write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            wr_count_q   <= wr_count_d;
        end
    end

    assign bus.ENA_WRITE  = ena_write_q;
    assign bus.WRITE_REG  = write_reg_q;
    assign bus.WRITE_DATA = write_data_q;
    assign bus.WR_COUNT   = wr_count_q;

    // Source-register compares against pending requesters and the
    // output stage.
    always_comb begin
        hit_a1 = bus.A_VALID && (bus.A_REG == bus.RS1);
        hit_b1 = bus.B_VALID && (bus.B_REG == bus.RS1);
        hit_f1 = ena_write_q && (write_reg_q == bus.RS1);
        hit_a2 = bus.A_VALID && (bus.A_REG == bus.RS2);
        hit_b2 = bus.B_VALID && (bus.B_REG == bus.RS2);
        hit_f2 = ena_write_q && (write_reg_q == bus.RS2);
    end

`ifdef REGBANK_BYPASS_EN
    // The in-flight write is forwarded, so only pending requesters stall.
    always_comb begin
        bus.HAZ1       = !RST && (bus.RS1 != '0) && (hit_a1 || hit_b1);
        bus.HAZ2       = !RST && (bus.RS2 != '0) && (hit_a2 || hit_b2);
        bus.BYP1_VALID = !RST && (bus.RS1 != '0) && hit_f1;
        bus.BYP2_VALID = !RST && (bus.RS2 != '0) && hit_f2;
        bus.BYP1_DATA  = bus.BYP1_VALID ? write_data_q : '0;
        bus.BYP2_DATA  = bus.BYP2_VALID ? write_data_q : '0;
    end
`else
    always_comb begin
        bus.HAZ1       = !RST && (bus.RS1 != '0) && (hit_a1 || hit_b1 || hit_f1);
        bus.HAZ2       = !RST && (bus.RS2 != '0) && (hit_a2 || hit_b2 || hit_f2);
        bus.BYP1_VALID = 1'b0;
        bus.BYP2_VALID = 1'b0;
        bus.BYP1_DATA  = '0;
        bus.BYP2_DATA  = '0;
    end
`endif

endmodule

// File: tb/tb_regbank_wport_arb.sv
module tb_regbank_wport_arb;

    import regbank_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    regbank_wport_arb_if #(.SIZE(SIZE), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    regbank_wport_arb #(.SIZE(SIZE), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: who won last, what sits in the output stage, count.
    bit          m_last_a = 1'b0;
    bit          m_ena    = 1'b0;
    logic [4:0]  m_reg    = '0;
    logic [31:0] m_data   = '0;
    int unsigned m_cnt    = 0;

    function automatic bit exp_ga();
        return !RST && bus.A_VALID && (!bus.B_VALID || !m_last_a);
    endfunction

    function automatic bit exp_gb();
        return !RST && bus.B_VALID && (!bus.A_VALID || m_last_a);
    endfunction

    function automatic bit exp_byp_v(input logic [4:0] rs);
`ifdef REGBANK_BYPASS_EN
        return !RST && rs != 0 && m_ena && m_reg == rs;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit exp_haz(input logic [4:0] rs);
        bit inflight;
`ifdef REGBANK_BYPASS_EN
        inflight = 1'b0;
`else
        inflight = m_ena && m_reg == rs;
`endif
        return !RST && rs != 0 && (inflight ||
               (bus.A_VALID && bus.A_REG == rs) || (bus.B_VALID && bus.B_REG == rs));
    endfunction

    task automatic model_edge();
        bit ga, gb;
        logic [4:0]  r;
        logic [31:0] d;
        ga = exp_ga();
        gb = exp_gb();
        if (RST) begin
            m_last_a = 1'b0; m_ena = 1'b0; m_reg = '0; m_data = '0; m_cnt = 0;
            return;
        end
        m_ena = 1'b0;
        if (ga || gb) begin
            r = ga ? bus.A_REG  : bus.B_REG;
            d = ga ? bus.A_DATA : bus.B_DATA;
            m_last_a = ga;
            if (r != 0) begin
                m_ena = 1'b1; m_reg = r; m_data = d;
                if (m_cnt < 65535) m_cnt++;
            end
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        bus.A_VALID = 1'b0;
        bus.B_VALID = 1'b0;
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        bus.A_VALID = 1'b1; bus.A_REG = 5'd3; bus.A_DATA = 32'h1;
        bus.B_VALID = 1'b1; bus.B_REG = 5'd3; bus.B_DATA = 32'h2;
        bus.RS1 = 5'd3; bus.RS2 = 5'd3;
        #1;
        n_tests++; if (bus.A_READY !== 1'b0) begin n_fail++; $display("FAIL rst_a_ready: got %b exp 0", bus.A_READY); end
        n_tests++; if (bus.B_READY !== 1'b0) begin n_fail++; $display("FAIL rst_b_ready: got %b exp 0", bus.B_READY); end
        n_tests++; if (bus.HAZ1 !== 1'b0 || bus.HAZ2 !== 1'b0) begin n_fail++; $display("FAIL rst_haz: got %b%b exp 00", bus.HAZ1, bus.HAZ2); end
        n_tests++; if (bus.BYP1_VALID !== 1'b0 || bus.BYP2_VALID !== 1'b0) begin n_fail++; $display("FAIL rst_byp: got %b%b exp 00", bus.BYP1_VALID, bus.BYP2_VALID); end
        tick();
        n_tests++; if (bus.ENA_WRITE !== 1'b0) begin n_fail++; $display("FAIL rst_ena: got %b exp 0", bus.ENA_WRITE); end
        n_tests++; if (bus.WRITE_REG !== 5'd0 || bus.WRITE_DATA !== 32'd0) begin n_fail++; $display("FAIL rst_wr: got %0d/%h exp 0/0", bus.WRITE_REG, bus.WRITE_DATA); end
        n_tests++; if (bus.WR_COUNT !== 16'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d exp 0", bus.WR_COUNT); end
        bus.A_VALID = 1'b0; bus.B_VALID = 1'b0;
        bus.RS1 = 5'd0; bus.RS2 = 5'd0;
        RST = 1'b0;
    endtask

    task automatic test_single_write();
        bus.A_VALID = 1'b1; bus.A_REG = 5'd3; bus.A_DATA = 32'hDEAD_BEEF;
        #1;
        n_tests++; if (bus.A_READY !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b exp 1", bus.A_READY); end
        tick();
        bus.A_VALID = 1'b0;
        n_tests++; if (bus.ENA_WRITE !== 1'b1) begin n_fail++; $display("FAIL single_ena: got %b exp 1", bus.ENA_WRITE); end
        n_tests++; if (bus.WRITE_REG !== 5'd3) begin n_fail++; $display("FAIL single_reg: got %0d exp 3", bus.WRITE_REG); end
        n_tests++; if (bus.WRITE_DATA !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_data: got %h exp deadbeef", bus.WRITE_DATA); end
        n_tests++; if (bus.WR_COUNT !== 16'd1) begin n_fail++; $display("FAIL single_cnt: got %0d exp 1", bus.WR_COUNT); end
        tick();
        n_tests++; if (bus.ENA_WRITE !== 1'b0) begin n_fail++; $display("FAIL single_drain: got %b exp 0", bus.ENA_WRITE); end
    endtask

    task automatic test_round_robin();
        int a_idx = 0;
        int b_idx = 0;
        bit want_a;
        logic [4:0] exp_reg;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.A_VALID = 1'b1; bus.A_REG = 5'(8 + a_idx);  bus.A_DATA = 32'hA000_0000 + 32'(a_idx);
            bus.B_VALID = 1'b1; bus.B_REG = 5'(16 + b_idx); bus.B_DATA = 32'hB000_0000 + 32'(b_idx);
            want_a = (i % 2) == 0;
            exp_reg = want_a ? 5'(8 + a_idx) : 5'(16 + b_idx);
            #1;
            n_tests++; if (bus.A_READY !== want_a || bus.B_READY !== !want_a) begin n_fail++; $display("FAIL rr_grant%0d: got A%b B%b exp A%b B%b", i, bus.A_READY, bus.B_READY, want_a, !want_a); end
            tick();
            n_tests++; if (bus.ENA_WRITE !== 1'b1 || bus.WRITE_REG !== exp_reg) begin n_fail++; $display("FAIL rr_write%0d: got ena %b reg %0d exp ena 1 reg %0d", i, bus.ENA_WRITE, bus.WRITE_REG, exp_reg); end
            if (want_a) a_idx++; else b_idx++;
        end
        // Last grant was B, so A takes the next tie.
        bus.A_REG = 5'd9; bus.B_REG = 5'd17;
        #1;
        n_tests++; if (bus.A_READY !== 1'b1 || bus.B_READY !== 1'b0) begin n_fail++; $display("FAIL rr_last: got A%b B%b exp A1 B0", bus.A_READY, bus.B_READY); end
        bus.A_VALID = 1'b0; bus.B_VALID = 1'b0;
        tick();
        n_tests++; if (bus.WR_COUNT !== 16'd4) begin n_fail++; $display("FAIL rr_cnt: got %0d exp 4", bus.WR_COUNT); end
    endtask

    task automatic test_x0_write();
        bus.A_VALID = 1'b1; bus.A_REG = 5'd0; bus.A_DATA = 32'hFFFF_FFFF;
        #1;
        n_tests++; if (bus.A_READY !== 1'b1) begin n_fail++; $display("FAIL x0_ready: got %b exp 1", bus.A_READY); end
        tick();
        n_tests++; if (bus.ENA_WRITE !== 1'b0) begin n_fail++; $display("FAIL x0_ena: got %b exp 0", bus.ENA_WRITE); end
        n_tests++; if (bus.WR_COUNT !== 16'd4) begin n_fail++; $display("FAIL x0_cnt: got %0d exp 4", bus.WR_COUNT); end
        // The x0 grant used A's turn, so B wins the following tie.
        bus.A_REG = 5'd1; bus.B_VALID = 1'b1; bus.B_REG = 5'd2;
        #1;
        n_tests++; if (bus.B_READY !== 1'b1 || bus.A_READY !== 1'b0) begin n_fail++; $display("FAIL x0_turn: got A%b B%b exp A0 B1", bus.A_READY, bus.B_READY); end
        bus.A_VALID = 1'b0; bus.B_VALID = 1'b0;
    endtask

    task automatic test_same_reg();
        do_reset();
        bus.A_VALID = 1'b1; bus.A_REG = 5'd5; bus.A_DATA = 32'h11;
        bus.B_VALID = 1'b1; bus.B_REG = 5'd5; bus.B_DATA = 32'h22;
        #1;
        n_tests++; if (bus.A_READY !== 1'b1 || bus.B_READY !== 1'b0) begin n_fail++; $display("FAIL same_g1: got A%b B%b exp A1 B0", bus.A_READY, bus.B_READY); end
        tick();
        bus.A_VALID = 1'b0;
        n_tests++; if (bus.ENA_WRITE !== 1'b1 || bus.WRITE_REG !== 5'd5 || bus.WRITE_DATA !== 32'h11) begin n_fail++; $display("FAIL same_w1: got %b/%0d/%h exp 1/5/11", bus.ENA_WRITE, bus.WRITE_REG, bus.WRITE_DATA); end
        #1;
        n_tests++; if (bus.B_READY !== 1'b1) begin n_fail++; $display("FAIL same_g2: got %b exp 1", bus.B_READY); end
        tick();
        bus.B_VALID = 1'b0;
        n_tests++; if (bus.ENA_WRITE !== 1'b1 || bus.WRITE_REG !== 5'd5 || bus.WRITE_DATA !== 32'h22) begin n_fail++; $display("FAIL same_w2: got %b/%0d/%h exp 1/5/22", bus.ENA_WRITE, bus.WRITE_REG, bus.WRITE_DATA); end
        tick();
        n_tests++; if (bus.ENA_WRITE !== 1'b0 || bus.WR_COUNT !== 16'd2) begin n_fail++; $display("FAIL same_end: got ena %b cnt %0d exp ena 0 cnt 2", bus.ENA_WRITE, bus.WR_COUNT); end
    endtask

    task automatic test_hazard();
        do_reset();
        bus.B_VALID = 1'b1; bus.B_REG = 5'd5; bus.B_DATA = 32'h5555_AAAA;
        bus.RS1 = 5'd5; bus.RS2 = 5'd0;
        #1;
        n_tests++; if (bus.HAZ1 !== 1'b1) begin n_fail++; $display("FAIL haz_pend: got %b exp 1", bus.HAZ1); end
        bus.RS1 = 5'd0;
        #1;
        n_tests++; if (bus.HAZ1 !== 1'b0) begin n_fail++; $display("FAIL haz_x0: got %b exp 0", bus.HAZ1); end
        tick();
        bus.B_VALID = 1'b0;
        bus.RS1 = 5'd6; bus.RS2 = 5'd5;
        #1;
        n_tests++; if (bus.HAZ1 !== 1'b0) begin n_fail++; $display("FAIL haz_nomatch: got %b exp 0", bus.HAZ1); end
`ifdef REGBANK_BYPASS_EN
        n_tests++; if (bus.HAZ2 !== 1'b0) begin n_fail++; $display("FAIL haz_inflight: got %b exp 0", bus.HAZ2); end
        n_tests++; if (bus.BYP2_VALID !== 1'b1 || bus.BYP2_DATA !== 32'h5555_AAAA) begin n_fail++; $display("FAIL byp2: got %b/%h exp 1/5555aaaa", bus.BYP2_VALID, bus.BYP2_DATA); end
        n_tests++; if (bus.BYP1_VALID !== 1'b0) begin n_fail++; $display("FAIL byp1: got %b exp 0", bus.BYP1_VALID); end
`else
        n_tests++; if (bus.HAZ2 !== 1'b1) begin n_fail++; $display("FAIL haz_inflight: got %b exp 1", bus.HAZ2); end
        n_tests++; if (bus.BYP2_VALID !== 1'b0 || bus.BYP2_DATA !== 32'd0) begin n_fail++; $display("FAIL byp2: got %b/%h exp 0/0", bus.BYP2_VALID, bus.BYP2_DATA); end
`endif
        tick();
        bus.RS1 = 5'd0; bus.RS2 = 5'd0;
    endtask

    task automatic test_reset_inflight();
        bus.A_VALID = 1'b1; bus.A_REG = 5'd7; bus.A_DATA = 32'hCAFE_0007;
        tick();
        bus.A_VALID = 1'b0;
        n_tests++; if (bus.ENA_WRITE !== 1'b1) begin n_fail++; $display("FAIL rstif_pre: got %b exp 1", bus.ENA_WRITE); end
        RST = 1'b1;
        tick();
        n_tests++; if (bus.ENA_WRITE !== 1'b0 || bus.WRITE_REG !== 5'd0 || bus.WRITE_DATA !== 32'd0) begin n_fail++; $display("FAIL rstif_out: got %b/%0d/%h exp 0/0/0", bus.ENA_WRITE, bus.WRITE_REG, bus.WRITE_DATA); end
        n_tests++; if (bus.WR_COUNT !== 16'd0) begin n_fail++; $display("FAIL rstif_cnt: got %0d exp 0", bus.WR_COUNT); end
        RST = 1'b0;
        tick();
        n_tests++; if (bus.ENA_WRITE !== 1'b0) begin n_fail++; $display("FAIL rstif_post: got %b exp 0", bus.ENA_WRITE); end
    endtask

    task automatic test_random();
        bit a_pend = 1'b0;
        bit b_pend = 1'b0;
        bit ga, gb;
        for (int c = 0; c < 400; c++) begin
            if (!a_pend && $urandom_range(0, 3) != 0) begin
                a_pend = 1'b1; bus.A_REG = 5'($urandom_range(0, 7)); bus.A_DATA = $urandom;
            end
            if (!b_pend && $urandom_range(0, 3) != 0) begin
                b_pend = 1'b1; bus.B_REG = 5'($urandom_range(0, 7)); bus.B_DATA = $urandom;
            end
            bus.A_VALID = a_pend;
            bus.B_VALID = b_pend;
            bus.RS1 = 5'($urandom_range(0, 7));
            bus.RS2 = 5'($urandom_range(0, 7));
            #1;
            ga = exp_ga();
            gb = exp_gb();
            n_tests++; if (bus.A_READY !== ga || bus.B_READY !== gb) begin n_fail++; $display("FAIL rnd_grant c%0d: got A%b B%b exp A%b B%b", c, bus.A_READY, bus.B_READY, ga, gb); end
            n_tests++; if (bus.HAZ1 !== exp_haz(bus.RS1) || bus.HAZ2 !== exp_haz(bus.RS2)) begin n_fail++; $display("FAIL rnd_haz c%0d: got %b%b exp %b%b", c, bus.HAZ1, bus.HAZ2, exp_haz(bus.RS1), exp_haz(bus.RS2)); end
            n_tests++; if (bus.BYP1_VALID !== exp_byp_v(bus.RS1) || bus.BYP2_VALID !== exp_byp_v(bus.RS2)
                           || bus.BYP1_DATA !== (exp_byp_v(bus.RS1) ? m_data : 32'd0)
                           || bus.BYP2_DATA !== (exp_byp_v(bus.RS2) ? m_data : 32'd0)) begin
                n_fail++; $display("FAIL rnd_byp c%0d: got %b/%h %b/%h", c, bus.BYP1_VALID, bus.BYP1_DATA, bus.BYP2_VALID, bus.BYP2_DATA);
            end
            tick();
            if (ga) a_pend = 1'b0;
            if (gb) b_pend = 1'b0;
            n_tests++; if (bus.ENA_WRITE !== m_ena) begin n_fail++; $display("FAIL rnd_ena c%0d: got %b exp %b", c, bus.ENA_WRITE, m_ena); end
            if (m_ena) begin
                n_tests++; if (bus.WRITE_REG !== m_reg || bus.WRITE_DATA !== m_data) begin n_fail++; $display("FAIL rnd_wr c%0d: got %0d/%h exp %0d/%h", c, bus.WRITE_REG, bus.WRITE_DATA, m_reg, m_data); end
            end
            n_tests++; if (bus.WR_COUNT !== 16'(m_cnt)) begin n_fail++; $display("FAIL rnd_cnt c%0d: got %0d exp %0d", c, bus.WR_COUNT, m_cnt); end
        end
        bus.A_VALID = 1'b0; bus.B_VALID = 1'b0;
        tick();
    endtask

    initial begin
        bus.A_VALID = 1'b0; bus.A_REG = '0; bus.A_DATA = '0;
        bus.B_VALID = 1'b0; bus.B_REG = '0; bus.B_DATA = '0;
        bus.RS1 = '0; bus.RS2 = '0;
        RST = 1'b1;
        tick();
        test_reset();
        test_single_write();
        test_round_robin();
        test_x0_write();
        test_same_reg();
        test_hazard();
        test_reset_inflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
